// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes data/fetch requests into byte-wide RAM/IO transactions
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        need_cache,
  input  logic [2:0]  cache_size,
  input  logic [31:0] cache_addr,
  input  logic        cache_way,
  input  logic [31:0] cache_value,
  output logic        cache_ready,
  output logic [31:0] cache_result,
  input  logic        ifetch_valid,
  input  logic [31:0] ifetch_addr,
  input  logic        clear,
  output logic        ifetch_ready,
  output logic [31:0] ifetch_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [31:0] addr, value, data_q, word, ext;
  logic [2:0] n, cnt;
  logic src_f, zext, rdy_q, stall;
  logic [7:0] din, din_save;
  assign stall = addr[17:16] == 2'b11 && io_buffer_full;
  assign mem_a = addr + {29'b0, cnt};
  assign mem_dout = 8'(value >> {cnt, 3'b0});
  assign mem_wr = rdy && state == WRITE && !stall;
  assign cache_ready = state == DONE && !src_f;
  assign ifetch_ready = state == DONE && src_f && !clear;
  // after an rdy-low stretch mem_din reflects the frozen address, so use the byte saved when the stall began
  assign din = rdy_q ? mem_din : din_save;
  assign word = data_q | ({24'b0, din} << {cnt - 3'd1, 3'b0});
  assign ext = n == 3'd1 ? (zext ? {24'b0, word[7:0]} : {{24{word[7]}}, word[7:0]}) :
               n == 3'd2 ? (zext ? {16'b0, word[15:0]} : {{16{word[15]}}, word[15:0]}) : word;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = need_cache ? (cache_way ? WRITE : READ) :
                        (ifetch_valid && !clear) ? READ : IDLE;
      READ:  state_nx = (src_f && clear) ? IDLE : (cnt == n) ? DONE : READ;
      WRITE: state_nx = (!stall && cnt == n - 3'd1) ? DONE : WRITE;
      DONE:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
      din_save <= 8'h0;
    end else begin
      rdy_q <= rdy;
      if (rdy_q) din_save <= mem_din;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      value <= '0;
      data_q <= '0;
      n <= '0;
      cnt <= '0;
      src_f <= 1'b0;
      zext <= 1'b0;
      cache_result <= '0;
      ifetch_data <= '0;
    end else if (rdy) begin
      state <= state_nx;
      if (state == IDLE) begin
        cnt <= '0;
        data_q <= '0;
        if (need_cache) begin
          addr <= cache_addr;
          value <= cache_value;
          n <= cache_size[1] ? 3'd4 : cache_size[0] ? 3'd2 : 3'd1;
          zext <= cache_size[2];
          src_f <= 1'b0;
        end else if (ifetch_valid && !clear) begin
          addr <= ifetch_addr;
          value <= '0;
          n <= 3'd4;
          zext <= 1'b0;
          src_f <= 1'b1;
        end
      end else if (state == READ) begin
        cnt <= cnt + 3'd1;
        if (cnt != 3'd0) data_q <= word;
        if (cnt == n && !(src_f && clear)) begin
          if (src_f) ifetch_data <= word;
          else cache_result <= ext;
        end
      end else if (state == WRITE && !stall) begin
        cnt <= cnt + 3'd1;
        if (cnt == n - 3'd1) cache_result <= '0;
      end
    end
  end
endmodule
